// File: rtl/afifo_rd_stream.sv
// Read-side stream adapter for the dual-clock MAC FIFO: absorbs the FIFO's
// 1-cycle read latency into a 2-entry skid buffer and presents a valid/ready stream.
module afifo_rd_stream #(
  parameter int DATA_WIDTH  = 16,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   ainit_n,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_dout,
  input  logic                   fifo_rd_ack,
  input  logic                   flush,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COUNT_WIDTH-1:0] word_cnt,
  output logic                   overflow_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  occ_e                   state_r;
  occ_e                   state_nxt_s;
  logic                   pending_r;
  logic                   drop_r;
  logic                   valid_r;
  logic                   err_r;
  logic [COUNT_WIDTH-1:0] cnt_r;
  logic [DATA_WIDTH-1:0]  entry0_r;
  logic [DATA_WIDTH-1:0]  entry1_r;
  logic [DATA_WIDTH-1:0]  entry0_nxt_s;
  logic [DATA_WIDTH-1:0]  entry1_nxt_s;
  logic                   pop_s;
  logic                   push_s;
  logic                   ovf_s;
  logic                   rd_en_s;
  logic [1:0]             fill_s;

  assign pop_s  = valid_r && out_ready;
  // An ack belonging to a read issued before a flush must never reach the buffer.
  assign push_s = fifo_rd_ack && !flush && !drop_r;
  assign fill_s = 2'(state_r) + {1'b0, pending_r};

  // Read request: keep buffered words plus in-flight reads within the two slots.
  always_comb begin
    rd_en_s = 1'b0;
    if (!ainit_n || fifo_empty || flush) begin
      rd_en_s = 1'b0;
    end else if (fill_s < 2'd2) begin
      rd_en_s = 1'b1;
    end else if ((fill_s == 2'd2) && pop_s) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
  end

  // Skid-buffer next state: occupancy and entry shifting on push/pop.
  always_comb begin
    state_nxt_s  = state_r;
    entry0_nxt_s = entry0_r;
    entry1_nxt_s = entry1_r;
    ovf_s        = 1'b0;
    if (flush) begin
      state_nxt_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (push_s) begin
            state_nxt_s  = ONE;
            entry0_nxt_s = fifo_dout;
          end else begin
            state_nxt_s = EMPTY;
          end
        end
        ONE: begin
          case ({push_s, pop_s})
            2'b10: begin
              state_nxt_s  = TWO;
              entry1_nxt_s = fifo_dout;
            end
            2'b01: state_nxt_s = EMPTY;
            2'b11: entry0_nxt_s = fifo_dout;
            default: state_nxt_s = ONE;
          endcase
        end
        TWO: begin
          case ({push_s, pop_s})
            2'b10: ovf_s = 1'b1;
            2'b01: begin
              state_nxt_s  = ONE;
              entry0_nxt_s = entry1_r;
            end
            2'b11: begin
              entry0_nxt_s = entry1_r;
              entry1_nxt_s = fifo_dout;
            end
            default: state_nxt_s = TWO;
          endcase
        end
        default: state_nxt_s = EMPTY;
      endcase
    end
  end

  // State, buffer, counter and sticky error registers.
  always_ff @(posedge clk or negedge ainit_n) begin
    if (!ainit_n) begin
      state_r   <= EMPTY;
      pending_r <= 1'b0;
      drop_r    <= 1'b0;
      valid_r   <= 1'b0;
      err_r     <= 1'b0;
      cnt_r     <= {COUNT_WIDTH{1'b0}};
      entry0_r  <= {DATA_WIDTH{1'b0}};
      entry1_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      pending_r <= rd_en_s;
      drop_r    <= flush && pending_r;
      valid_r   <= (state_nxt_s != EMPTY);
      entry0_r  <= entry0_nxt_s;
      entry1_r  <= entry1_nxt_s;
      if (pop_s) begin
        cnt_r <= cnt_r + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
      end
      if (ovf_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign fifo_rd_en   = rd_en_s;
  assign out_data     = entry0_r;
  assign out_valid    = valid_r;
  assign word_cnt     = cnt_r;
  assign overflow_err = err_r;

endmodule

// File: tb/tb_afifo_rd_stream.sv
// Directed bench for afifo_rd_stream with a behavioural 1-cycle-latency FIFO
// model; word counter narrowed to 4 bits to exercise wrap-around.
module tb_afifo_rd_stream;

  logic        clk = 1'b0;
  logic        ainit_n;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [15:0] fifo_dout;
  logic        fifo_rd_ack;
  logic        flush;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  word_cnt;
  logic        overflow_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] fq[$];

  logic [15:0] d2 [10] = '{16'h0, 16'h0, 16'hA001, 16'hB002, 16'hC003,
                           16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
  logic [15:0] d3 [10] = '{16'h0, 16'h0, 16'h3A01, 16'h3A01, 16'h3A01,
                           16'h3A01, 16'h3B02, 16'h3C03, 16'h0, 16'h0};
  logic [15:0] d4 [10] = '{16'h0, 16'h0, 16'h4E01, 16'h4E01, 16'h4F02,
                           16'h0, 16'h0, 16'h4D04, 16'h0, 16'h0};
  logic [15:0] d5 [10] = '{16'h0, 16'h0, 16'h5801, 16'h5801, 16'h5801,
                           16'h5801, 16'h5902, 16'h0, 16'h0, 16'h0};

  afifo_rd_stream #(.DATA_WIDTH(16), .COUNT_WIDTH(4)) dut (
    .clk          (clk),
    .ainit_n      (ainit_n),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_dout    (fifo_dout),
    .fifo_rd_ack  (fifo_rd_ack),
    .flush        (flush),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .word_cnt     (word_cnt),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; FIFO model answers a read sampled before the edge with an ack after it.
  task automatic tick();
    logic rd_s;
    #1;
    rd_s = fifo_rd_en;
    @(posedge clk);
    #1;
    if (rd_s && (fq.size() > 0)) begin
      fifo_rd_ack = 1'b1;
      fifo_dout   = fq.pop_front();
    end else begin
      fifo_rd_ack = 1'b0;
      fifo_dout   = 16'h0;
    end
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic load3(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    fq.push_back(a);
    fq.push_back(b);
    fq.push_back(c);
    fifo_empty = 1'b0;
  endtask

  // Per-cycle vectors: bit c of each vector applies to cycle c.
  task automatic run_seq(input string tag, input int n, input logic [9:0] rdy,
                         input logic [9:0] fl, input logic [9:0] rd, input logic [9:0] v,
                         input logic [9:0] err, input logic [15:0] d [10], input int inj);
    for (int c = 0; c < n; c++) begin
      out_ready = rdy[c];
      flush     = fl[c];
      #1;
      chk($sformatf("%s_rd_c%0d", tag, c), {31'd0, fifo_rd_en}, {31'd0, rd[c]});
      chk($sformatf("%s_valid_c%0d", tag, c), {31'd0, out_valid}, {31'd0, v[c]});
      if (v[c]) begin
        chk($sformatf("%s_data_c%0d", tag, c), {16'd0, out_data}, {16'd0, d[c]});
      end
      chk($sformatf("%s_err_c%0d", tag, c), {31'd0, overflow_err}, {31'd0, err[c]});
      if (c == inj) begin
        fifo_rd_ack = 1'b1;
        fifo_dout   = 16'hDEAD;
      end
      tick();
    end
    flush     = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    int rx;
    logic [15:0] exp_w;
    ainit_n     = 1'b0;
    fifo_empty  = 1'b1;
    fifo_dout   = 16'h0;
    fifo_rd_ack = 1'b0;
    flush       = 1'b0;
    out_ready   = 1'b0;

    // Reset held with random inputs.
    for (int i = 0; i < 5; i++) begin
      fifo_empty  = 1'($urandom_range(0, 1));
      flush       = 1'($urandom_range(0, 1));
      out_ready   = 1'($urandom_range(0, 1));
      fifo_rd_ack = 1'($urandom_range(0, 1));
      fifo_dout   = 16'($urandom);
      @(posedge clk);
      #1;
      chk("rst_rd", {31'd0, fifo_rd_en}, 32'd0);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_data", {16'd0, out_data}, 32'd0);
      chk("rst_cnt", {28'd0, word_cnt}, 32'd0);
      chk("rst_err", {31'd0, overflow_err}, 32'd0);
    end
    fifo_empty  = 1'b1;
    flush       = 1'b0;
    out_ready   = 1'b0;
    fifo_rd_ack = 1'b0;
    fifo_dout   = 16'h0;
    ainit_n     = 1'b1;
    #1;
    chk("post_rst_rd0", {31'd0, fifo_rd_en}, 32'd0);
    tick();
    chk("post_rst_rd1", {31'd0, fifo_rd_en}, 32'd0);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

    // Streaming with out_ready high: no bubbles.
    load3(16'hA001, 16'hB002, 16'hC003);
    run_seq("t2", 6, 10'b1111111111, 10'b0, 10'b0000000111, 10'b0000011100, 10'b0, d2, -1);
    chk("t2_cnt", {28'd0, word_cnt}, 32'd3);

    // Backpressure: two reads, stable head, then drain in order.
    load3(16'h3A01, 16'h3B02, 16'h3C03);
    run_seq("t3", 9, 10'b0111100000, 10'b0, 10'b0000100011, 10'b0011111100, 10'b0, d3, -1);
    chk("t3_cnt", {28'd0, word_cnt}, 32'd6);

    // Flush with a read in flight; the in-flight word is discarded.
    load3(16'h4E01, 16'h4F02, 16'h4603);
    fq.push_back(16'h4D04);
    run_seq("t4", 9, 10'b0010001000, 10'b0000010000, 10'b0000101011, 10'b0010011100, 10'b0, d4, -1);
    chk("t4_cnt", {28'd0, word_cnt}, 32'd8);
    chk("t4_err", {31'd0, overflow_err}, 32'd0);

    // Spurious ack into a full buffer sets the sticky error.
    fq.push_back(16'h5801);
    fq.push_back(16'h5902);
    fifo_empty = 1'b0;
    run_seq("t5", 8, 10'b0011100000, 10'b0, 10'b0000000011, 10'b0001111100, 10'b0011110000, d5, 3);
    chk("t5_cnt", {28'd0, word_cnt}, 32'd10);
    chk("t5_err_sticky", {31'd0, overflow_err}, 32'd1);

    // Fresh reset, then 17 transfers wrap the 4-bit counter to 1.
    ainit_n = 1'b0;
    #1;
    chk("t6_rst_cnt", {28'd0, word_cnt}, 32'd0);
    chk("t6_rst_err", {31'd0, overflow_err}, 32'd0);
    @(posedge clk);
    #1;
    ainit_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      fq.push_back(16'h6000 + 16'(i));
    end
    fifo_empty = 1'b0;
    out_ready  = 1'b1;
    rx = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (out_valid) begin
        exp_w = 16'h6000 + 16'(rx);
        chk($sformatf("t6_data_%0d", rx), {16'd0, out_data}, {16'd0, exp_w});
        rx++;
      end
      tick();
      if (rx >= 17) break;
    end
    chk("t6_words", rx, 32'd17);
    chk("t6_cnt_wrap", {28'd0, word_cnt}, 32'd1);
    out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
